// File: rtl/uart_bcd_receiver_if.sv
// Serial input and result/status outputs of the UART BCD receiver.
// The slave side is the receiver; the master side is whatever feeds the line
// and consumes the committed number.
interface uart_bcd_receiver_if;
  logic        i_rx;
  logic [31:0] o_number;
  logic        o_number_valid;
  logic        o_parse_err;
  logic        o_frame_err;
  logic        o_busy;

  modport slave (
    input  i_rx,
    output o_number,
    output o_number_valid,
    output o_parse_err,
    output o_frame_err,
    output o_busy
  );

  modport master (
    output i_rx,
    input  o_number,
    input  o_number_valid,
    input  o_parse_err,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_bcd_receiver.sv
// 8N1 UART receiver feeding an ASCII-decimal parser. Digits shift into an
// 8-digit packed BCD working register; a CR or LF commits it to o_number.
module uart_bcd_receiver #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIGITS = 8
) (
  input  logic i_iclk,
  input  logic i_rst_n,
  uart_bcd_receiver_if.slave bus
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [31:0] work;
  logic [3:0]  count;
  logic        rx_m, rx_s, rx_d;

  // Byte classification of the assembled shift register.
  logic is_digit, is_term;
  assign is_digit = (shreg >= 8'h30) && (shreg <= 8'h39);
  assign is_term  = (shreg == 8'h0D) || (shreg == 8'h0A);

  assign bus.o_busy = (state != IDLE);

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  // NOTE: these flops reset to 1 (line idle) so reset release never looks
  // like a start-bit edge.
  always_ff @(posedge i_iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.i_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Bit FSM with the parser folded into the stop-bit sample, so results
  // appear in the cycle right after that sample.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge i_iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      bit_idx            <= '0;
      shreg              <= '0;
      work               <= '0;
      count              <= '0;
      bus.o_number       <= '0;
      bus.o_number_valid <= 1'b0;
      bus.o_parse_err    <= 1'b0;
      bus.o_frame_err    <= 1'b0;
    end else begin
      bus.o_number_valid <= 1'b0;
      bus.o_parse_err    <= 1'b0;
      bus.o_frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              bus.o_frame_err <= 1'b1;
            end else if (is_digit) begin
              work <= {work[27:0], shreg[3:0]};
              if (count != 4'(DIGITS)) count <= count + 4'd1;
            end else if (is_term) begin
              if (count != 4'd0) begin
                bus.o_number       <= work;
                bus.o_number_valid <= 1'b1;
                work               <= '0;
                count              <= '0;
              end
            end else begin
              bus.o_parse_err <= 1'b1;
              work            <= '0;
              count           <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bcd_receiver.sv
// Directed bench for uart_bcd_receiver: a byte-level model pushes expected
// pulses into a scoreboard queue; a negedge monitor pops and compares them.
module tb_uart_bcd_receiver;
  localparam int CLK_HZ = 921600;
  localparam int BAUD   = 115200;
  localparam int CPB    = 8;
  localparam int HALF   = 4;

  typedef enum logic [1:0] {EV_VALID, EV_PARSE, EV_FRAME} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] number;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_bcd_receiver_if bus ();

  uart_bcd_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIGITS(8)) dut (
    .i_iclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  ev_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_work = '0;
  logic [31:0] m_number = '0;
  int          m_count = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected effect of one received frame.
  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    ev_t e;
    if (!stop_ok) begin
      e.kind = EV_FRAME; e.number = m_number; sb.push_back(e);
    end else if (b >= 8'h30 && b <= 8'h39) begin
      m_work = {m_work[27:0], b[3:0]};
      if (m_count < 8) m_count++;
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (m_count > 0) begin
        m_number = m_work;
        e.kind = EV_VALID; e.number = m_number; sb.push_back(e);
        m_work = '0; m_count = 0;
      end
    end else begin
      e.kind = EV_PARSE; e.number = m_number; sb.push_back(e);
      m_work = '0; m_count = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    model_byte(b, stop_bit);
    bus.i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.i_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input string tag);
    repeat (4 * CPB) @(negedge clk);
    check({"sb_empty_", tag}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, be the only
  // pulse that cycle, and coincide with busy having just dropped.
  always @(negedge clk) begin
    int          n;
    ev_t         e;
    logic [31:0] kind_obs;
    if (rst_n) begin
      n = int'(bus.o_number_valid) + int'(bus.o_parse_err) + int'(bus.o_frame_err);
      if (n != 0) begin
        check("one_pulse", 32'(n), 32'd1);
        kind_obs = bus.o_number_valid ? 32'(EV_VALID) :
                   bus.o_parse_err    ? 32'(EV_PARSE) : 32'(EV_FRAME);
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_pulse observed=kind%0d expected=no_pulse", kind_obs);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pulse_kind", kind_obs, 32'(e.kind));
          check("pulse_number", bus.o_number, e.number);
          check("latency_busy_prev", 32'(prev_busy), 32'd1);
          check("latency_busy_now", 32'(bus.o_busy), 32'd0);
        end
      end
    end
    prev_busy = rst_n ? bus.o_busy : 1'b0;
  end

  initial begin
    logic seen;
    bus.i_rx = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_number", bus.o_number, 32'h0);
    check("rst_valid", 32'(bus.o_number_valid), 32'd0);
    check("rst_parse", 32'(bus.o_parse_err), 32'd0);
    check("rst_frame", 32'(bus.o_frame_err), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_str("1234"); send_byte(8'h0D);
    drain("t1");
    check("t1_number", bus.o_number, 32'h00001234);

    send_str("123456789"); send_byte(8'h0A);
    drain("t2");
    check("t2_number", bus.o_number, 32'h23456789);

    send_str("12"); send_byte(8'h0D); send_byte(8'h0A);
    drain("t3");
    check("t3_number", bus.o_number, 32'h00000012);

    send_str("1A5"); send_byte(8'h0D);
    drain("t4");
    check("t4_number", bus.o_number, 32'h00000005);

    send_str("3"); send_byte(8'h37, 1'b0); send_byte(8'h0D);
    drain("t5");
    check("t5_number", bus.o_number, 32'h00000003);

    // Two-clock glitch: busy must rise, then fall back within HALF+3 clocks.
    bus.i_rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.i_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < HALF + 3; i++) begin
      @(negedge clk);
      if (bus.o_busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 32'd1);
    check("glitch_busy_idle", 32'(bus.o_busy), 32'd0);
    drain("glitch");

    // Reset in the middle of the DATA phase clears everything without a clock edge.
    bus.i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("mid_data_busy", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_number", bus.o_number, 32'h0);
    check("async_rst_valid", 32'(bus.o_number_valid), 32'd0);
    check("async_rst_parse", 32'(bus.o_parse_err), 32'd0);
    check("async_rst_frame", 32'(bus.o_frame_err), 32'd0);
    check("async_rst_busy", 32'(bus.o_busy), 32'd0);
    m_work = '0; m_count = 0; m_number = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_str("9"); send_byte(8'h0D);
    drain("t6");
    check("t6_number", bus.o_number, 32'h00000009);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_bcd_receiver.md
Name: uart_bcd_receiver

Overview:
Upstream feeder for the button-adjust stage. Deserialises 8N1 UART traffic from the host and parses ASCII decimal digits into an 8-digit packed BCD number. The number is committed on a line terminator. o_number drives the received-number input of the button stage.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate
DIGITS, 8, BCD digits held; fixed at 8 in this revision, sizes o_number as 4*DIGITS

Ports:
i_iclk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  UART serial line, idle high, asynchronous to i_iclk
o_number  output  32  committed BCD number; [31:28] = most significant digit, [3:0] = least significant digit
o_number_valid  output  1  one-cycle pulse when o_number updates
o_parse_err  output  1  one-cycle pulse on an illegal byte
o_frame_err  output  1  one-cycle pulse on a bad stop bit
o_busy  output  1  high while the bit FSM is not IDLE

Behaviour:
- Clock and reset: single clock i_iclk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_number=0, o_number_valid=0, o_parse_err=0, o_frame_err=0, o_busy=0. FSM=IDLE, working register=0, digit count=0, synchroniser flops=1.
- Reset mid-frame abandons the frame and the partial line. No pulse is emitted.
- Synchroniser: 2-flop synchroniser on i_rx. All logic uses the synchronised signal rx_s.
- Bit timing: CLKS_PER_BIT = CLK_HZ/BAUD (integer division). HALF = CLKS_PER_BIT/2. Counter width is clog2(CLKS_PER_BIT)+1.
- Bit FSM states are IDLE, START, DATA, STOP.
  - IDLE: go to START on a 1->0 transition of rx_s.
  - START: wait HALF clocks. If rx_s=0, go to DATA; otherwise treat as a glitch and return to IDLE with no pulse.
  - DATA: sample rx_s every CLKS_PER_BIT clocks at mid-bit, 8 bits, LSB first. Go to STOP after bit 7.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx_s=1: byte accepted.
    - rx_s=0: pulse o_frame_err and discard the byte. The digit count and working register are unchanged.
  - After either STOP outcome, return to IDLE. IDLE needs a fresh 1->0 edge, so a stuck-low line does not retrigger.
- Parser: acts on an accepted byte in the cycle after the stop sample.
  - Byte 0x30..0x39: work <= {work[27:0], byte[3:0]}. count <= min(count+1, DIGITS).
  - Digit overflow: beyond 8 digits the oldest (most significant) digit is shifted out and dropped.
  - Byte 0x0D or 0x0A with count>0: o_number <= work (right-aligned, leading zeros). Pulse o_number_valid. Clear work and count.
  - Byte 0x0D or 0x0A with count=0: ignored, no pulse. This makes CRLF yield exactly one commit.
  - Any other byte: pulse o_parse_err. Clear work and count, discarding the line. o_number is unchanged.
- Latency: o_number and o_number_valid update exactly 1 cycle after the cycle of the terminator's stop-bit sample. The error pulses follow the same 1-cycle rule.
- o_number holds its value between commits. At most one of valid, parse_err or frame_err is high in any cycle.
- o_busy is high in START, DATA and STOP.

Test Plan:
All tests use CLK_HZ=921600, BAUD=115200, so CLKS_PER_BIT=8.
- Send "1234\r" -> o_number=32'h00001234. o_number_valid high for exactly 1 cycle, 1 clock after the '\r' stop sample. No error pulses.
- Send "123456789\n" -> o_number=32'h23456789 (MSD dropped). Single valid pulse.
- Send "12\r\n" -> exactly one valid pulse, o_number=32'h00000012. The second terminator gives no pulse.
- Send "1A5\r" -> o_parse_err pulse after 'A'. Then o_number=32'h00000005 with one valid pulse.
- Send "3", then a frame 0x37 with stop bit forced 0, then "\r" -> o_frame_err pulse on the bad frame, then o_number=32'h00000003.
- Drive i_rx low for 2 clocks -> o_busy drops within HALF+3 clocks, no pulses. Then assert i_rst_n=0 mid-DATA of the next frame -> all outputs 0 immediately, with no clock edge needed. A subsequent clean "9\r" gives o_number=32'h00000009.
